mem_access_ctrl: RTL and testbench

Bus initiator that drives the 18-bit/13-bit-address processor memory on behalf of the core. Accepts one load or store request at a time over a valid/ready handshake. Sequences the memory's mutually exclusive read/write enables and captures the registered read data. Returns a single response per request, flagging addresses beyond the populated memory depth without touching memory.

---
 rtl/mem_access_ctrl.sv | 107 ++++++++++
 tb/tb_mem_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the 18-bit x 13-bit-address processor memory.
// One request in flight; registered read data returned after READ_LAT edges.
module mem_access_ctrl #(
  parameter int MEM_DEPTH = 16,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [12:0] req_addr,
  input  logic [17:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [17:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_re_en,
  output logic        mem_wr_en,
  output logic [12:0] mem_address,
  output logic [17:0] mem_wdata,
  input  logic [17:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_t;

  localparam logic [2:0]  CNT_INIT = 3'(READ_LAT - 1);
  localparam logic [13:0] DEPTH    = 14'(MEM_DEPTH);

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic       accept;
  logic       addr_bad;
  logic       rd_done;

  assign accept   = (state == IDLE) && req_valid;
  assign addr_bad = {1'b0, req_addr} >= DEPTH;
  assign rd_done  = (state == RD_WAIT) && (cnt == 3'd0);

  // reset gates req_ready so the core never sees IDLE while held in reset
  assign req_ready  = (state == IDLE) && rst;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign mem_re_en  = (state == RD_ISSUE);
  assign mem_wr_en  = (state == WR_ISSUE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            addr_bad:            state_nx = RESP;
            !addr_bad && req_we:  state_nx = WR_ISSUE;
            !addr_bad && !req_we: state_nx = RD_ISSUE;
            default:             state_nx = IDLE;
          endcase
        end
      end
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  if (cnt == 3'd0) state_nx = RESP;
      WR_ISSUE: state_nx = RESP;
      RESP:     if (resp_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        mem_address <= req_addr;
        mem_wdata   <= req_wdata;
        if (addr_bad) resp_err <= 1'b1;
      end
      if (state == RD_ISSUE) cnt <= CNT_INIT;
      if (state == RD_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (rd_done) begin
        resp_rdata <= mem_rdata;
        resp_err   <= 1'b0;
      end
      if (state == WR_ISSUE) resp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: two instances (READ_LAT 1 and 3)
// against a transaction-level reference model and a behavioural memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [12:0] req_addr [2];
  logic [17:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [17:0] resp_rdata [2];
  logic        resp_err [2];
  logic        busy [2];
  logic        mem_re_en [2];
  logic        mem_wr_en [2];
  logic [12:0] mem_address [2];
  logic [17:0] mem_wdata [2];
  logic [17:0] mem_rdata [2];

  int total = 0;
  int bad = 0;

  localparam logic [17:0] INIT [16] = '{
    18'h00011, 18'h3ffff, 18'h12345, 18'h00a5a,
    18'h2aaaa, 18'h15555, 18'h00777, 18'h30303,
    18'h0beef, 18'h1cafe, 18'h0f0f0, 18'h3c3c3,
    18'h00001, 18'd42,    18'd3,     18'h20000
  };
  localparam int LAT [2] = '{1, 3};

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_DEPTH(16), .READ_LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]),
    .mem_re_en(mem_re_en[0]), .mem_wr_en(mem_wr_en[0]),
    .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  mem_access_ctrl #(.MEM_DEPTH(16), .READ_LAT(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]),
    .mem_re_en(mem_re_en[1]), .mem_wr_en(mem_wr_en[1]),
    .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  // behavioural memory: DataOut valid READ_LAT-1 edges after the
  // re_en sample edge, random junk at all other times
  logic [17:0] mem [2][16];
  logic [17:0] sd [2];
  int          cd [2];
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 16; a++) begin
        mem[0][a] <= INIT[a];
        mem[1][a] <= INIT[a];
      end
      cd[0] <= 0;
      cd[1] <= 0;
      loaded <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mem_wr_en[d] && mem_address[d] < 13'd16)
          mem[d][mem_address[d][3:0]] <= mem_wdata[d];
        if (mem_re_en[d]) begin
          if (LAT[d] == 1) begin
            mem_rdata[d] <= mem[d][mem_address[d][3:0]];
          end else begin
            cd[d] <= LAT[d] - 1;
            sd[d] <= mem[d][mem_address[d][3:0]];
            mem_rdata[d] <= 18'($urandom);
          end
        end else if (cd[d] != 0) begin
          cd[d] <= cd[d] - 1;
          mem_rdata[d] <= (cd[d] == 1) ? sd[d] : 18'($urandom);
        end else begin
          mem_rdata[d] <= 18'($urandom);
        end
      end
    end
  end

  logic [17:0] ref_mem [2][16];
  logic [17:0] ref_rd [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input int d, input bit we,
                         input logic [12:0] addr,
                         input logic [17:0] wd, input int hold);
    bit          err;
    bit          got;
    int          n;
    int          re_cnt;
    int          wr_cnt;
    int          exp_lat;
    logic [17:0] exp_rd;
    err = (addr >= 13'd16);
    exp_rd = (err || we) ? ref_rd[d] : ref_mem[d][addr[3:0]];
    exp_lat = err ? 0 : (we ? 1 : LAT[d] + 1);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[d]), 1);
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_addr[d] = addr;
    req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom);
    req_addr[d] = 13'($urandom);
    req_wdata[d] = 18'($urandom);
    n = 0;
    got = 1'b0;
    re_cnt = 0;
    wr_cnt = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      chk("excl", 32'(mem_re_en[d] && mem_wr_en[d]), 0);
      chk("ready_busy", 32'(req_ready[d]), 0);
      if (mem_re_en[d]) begin
        re_cnt++;
        chk("re_addr", 32'(mem_address[d]), 32'(addr));
      end
      if (mem_wr_en[d]) begin
        wr_cnt++;
        chk("wr_addr", 32'(mem_address[d]), 32'(addr));
        chk("wr_data", 32'(mem_wdata[d]), 32'(wd));
      end
      if (resp_valid[d]) got = 1'b1;
      else n++;
    end
    chk("resp_seen", 32'(got), 1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("re_pulses", 32'(re_cnt), (err || we) ? 0 : 1);
    chk("wr_pulses", 32'(wr_cnt), (!err && we) ? 1 : 0);
    chk("rdata", 32'(resp_rdata[d]), 32'(exp_rd));
    chk("err", 32'(resp_err[d]), 32'(err));
    chk("busy", 32'(busy[d]), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 1);
      chk("hold_rdata", 32'(resp_rdata[d]), 32'(exp_rd));
      chk("hold_err", 32'(resp_err[d]), 32'(err));
      chk("hold_ready", 32'(req_ready[d]), 0);
      chk("hold_en", 32'(mem_re_en[d] | mem_wr_en[d]), 0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    @(negedge clk);
    chk("back_idle", 32'(req_ready[d]), 1);
    chk("idle_busy", 32'(busy[d]), 0);
    chk("idle_valid", 32'(resp_valid[d]), 0);
    if (!err && we) ref_mem[d][addr[3:0]] = wd;
    if (!err && !we) ref_rd[d] = exp_rd;
  endtask

  task automatic chk_reset_outs(input int d);
    chk("rst_ready", 32'(req_ready[d]), 0);
    chk("rst_valid", 32'(resp_valid[d]), 0);
    chk("rst_err", 32'(resp_err[d]), 0);
    chk("rst_busy", 32'(busy[d]), 0);
    chk("rst_en", 32'(mem_re_en[d] | mem_wr_en[d]), 0);
    chk("rst_addr", 32'(mem_address[d]), 0);
    chk("rst_wdata", 32'(mem_wdata[d]), 0);
    chk("rst_rdata", 32'(resp_rdata[d]), 0);
  endtask

  task automatic release_and_idle();
    @(negedge clk);
    rst = 1'b1;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("post_rst_valid", 32'(resp_valid[d]), 0);
        chk("post_rst_ready", 32'(req_ready[d]), 1);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
      resp_ready[d] = 1'b0;
      ref_rd[d] = '0;
      for (int a = 0; a < 16; a++) ref_mem[d][a] = INIT[a];
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_txn(0, 1'b0, 13'd13, 18'd0, 0);
    run_txn(0, 1'b1, 13'd15, 18'd45, 0);
    run_txn(0, 1'b0, 13'd15, 18'd0, 0);
    run_txn(0, 1'b0, 13'd16, 18'd0, 0);
    run_txn(0, 1'b0, 13'd8191, 18'd0, 0);
    run_txn(0, 1'b1, 13'd16, 18'h1234, 1);
    run_txn(0, 1'b0, 13'd13, 18'd0, 5);
    run_txn(1, 1'b0, 13'd14, 18'd0, 0);
    run_txn(1, 1'b0, 13'd16, 18'd0, 2);

    // reset in WR_ISSUE: store must not complete or respond
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[0] = 13'd5;
    req_wdata[0] = 18'h2f2f2;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("pre_rst_wr", 32'(mem_wr_en[0]), 1);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outs(0);
    chk_reset_outs(1);
    release_and_idle();
    run_txn(0, 1'b0, 13'd5, 18'd0, 0);

    // reset in RD_WAIT on the READ_LAT=3 instance
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    req_addr[1] = 13'd14;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_rdwait", 32'(busy[1] && !mem_re_en[1]), 1);
    rst = 1'b0;
    #1;
    chk_reset_outs(0);
    chk_reset_outs(1);
    release_and_idle();
    run_txn(1, 1'b0, 13'd14, 18'd0, 0);

    for (int i = 0; i < 60; i++) begin
      int          d;
      logic [12:0] a;
      d = i % 2;
      a = ($urandom_range(0, 4) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15));
      run_txn(d, 1'($urandom), a, 18'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
